btn_conditioner: RTL and testbench

Conditions the raw board push-buttons before they reach the HDMI pattern/control logic in the pixel-clock domain. Each button is synchronised with two flops, debounced with a per-button stability counter, and converted into a clean level plus single-cycle press/release pulses. An optional auto-repeat engine re-issues press pulses while a button is held. The block sits between the `btn` pins and the `btn` input of the HDMI core, clocked by the pixel clock.

---
 rtl/btn_conditioner.sv | 105 ++++++++++
 tb/tb_btn_conditioner.sv | 119 +++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronise, debounce and edge-detect push-buttons, optional auto-repeat.
// Define BTN_CONDITIONER_REPEAT_EN to re-issue press pulses while a button is held.
`timescale 1ns/1ps
module btn_conditioner #(
    parameter int N_BTN           = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 371250,
    parameter int REPEAT_DELAY    = 29700000,
    parameter int REPEAT_PERIOD   = 7425000
) (
    input  logic             clk,
    input  logic             ext_reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("btn_conditioner: illegal timing parameter");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic raw_in, sync1, sync2, s, accept, rise, fall, rep, press_q, release_q;
        logic [CW-1:0] c;
        assign raw_in = (ACTIVE_LOW != 0) ? ~btn_raw[i] : btn_raw[i];
        assign accept = (sync2 != s) && (c == C_MAX);
        assign rise   = accept && sync2;
        assign fall   = accept && !sync2;

        always_ff @(posedge clk or negedge ext_reset) begin
            if (!ext_reset) begin
                sync1     <= 1'b0;
                sync2     <= 1'b0;
                s         <= 1'b0;
                c         <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                sync1     <= raw_in;
                sync2     <= sync1;
                s         <= accept ? sync2 : s;
                c         <= (sync2 == s || accept) ? '0 : c + CW'(1);
                press_q   <= rise || rep;
                release_q <= fall;
            end
        end

`ifdef BTN_CONDITIONER_REPEAT_EN
        localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
        localparam logic [RW-1:0] RD_MAX = RW'(REPEAT_DELAY - 1);
        localparam logic [RW-1:0] RP_MAX = RW'(REPEAT_PERIOD - 1);
        typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rstate_t;
        rstate_t state, state_n;
        logic [RW-1:0] r, r_n;

        always_ff @(posedge clk or negedge ext_reset) begin
            if (!ext_reset) begin
                state <= IDLE;
                r     <= '0;
            end else begin
                state <= state_n;
                r     <= r_n;
            end
        end

        // a release accepted in the same cycle suppresses any repeat falling due
        always_comb begin
            state_n = state;
            r_n     = r + RW'(1);
            rep     = 1'b0;
            case (state)
                IDLE: begin
                    r_n     = '0;
                    state_n = rise ? DELAY : IDLE;
                end
                DELAY: if (r == RD_MAX) begin
                    rep     = 1'b1;
                    state_n = REPEAT;
                    r_n     = '0;
                end
                REPEAT: if (r == RP_MAX) begin
                    rep = 1'b1;
                    r_n = '0;
                end
                default: state_n = IDLE;
            endcase
            if (fall) begin
                state_n = IDLE;
                r_n     = '0;
                rep     = 1'b0;
            end
        end
`else
        assign rep = 1'b0;
`endif

        assign btn_level[i]   = s;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed checks of debounce timing, pulses, reset and auto-repeat.
`timescale 1ns/1ps
module tb_btn_conditioner;
`ifdef BTN_CONDITIONER_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       ext_reset = 1'b0;
    logic [3:0] btn_raw = 4'hF;
    logic [3:0] btn_level, btn_press, btn_release;
    int n_assert = 0;
    int n_fail = 0;

    btn_conditioner #(
        .N_BTN(4), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(8), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk), .ext_reset(ext_reset), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // raw pins were just driven; acceptance lands n edges later
    task automatic accept(input string tag, input int n, input logic [3:0] lvl,
                          input logic [3:0] prs, input logic [3:0] rel);
        step(n - 1);
        chk({tag, "_pre_press"}, btn_press, 4'b0000);
        chk({tag, "_pre_release"}, btn_release, 4'b0000);
        step(1);
        chk({tag, "_level"}, btn_level, lvl);
        chk({tag, "_press"}, btn_press, prs);
        chk({tag, "_release"}, btn_release, rel);
        step(1);
        chk({tag, "_press_width"}, btn_press, 4'b0000);
        chk({tag, "_release_width"}, btn_release, 4'b0000);
    endtask

    initial begin
        step(3);
        chk("rst_level", btn_level, 4'b0000);
        chk("rst_press", btn_press, 4'b0000);
        chk("rst_release", btn_release, 4'b0000);
        ext_reset = 1'b1;
        step(5);
        chk("idle_level", btn_level, 4'b0000);
        // clean press and release of button 0
        btn_raw[0] = 1'b0;
        accept("press0", 10, 4'b0001, 4'b0001, 4'b0000);
        btn_raw[0] = 1'b1;
        accept("rel0", 10, 4'b0000, 4'b0000, 4'b0001);
        // bounce on button 1: 7 low, 1 high, then steady low
        btn_raw[1] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(1);
            chk($sformatf("bounce_level_%0d", i), btn_level, 4'b0000);
            chk($sformatf("bounce_press_%0d", i), btn_press, 4'b0000);
        end
        btn_raw[1] = 1'b1;
        step(1);
        btn_raw[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk($sformatf("bounce_gap_%0d", i), btn_level, 4'b0000);
        end
        accept("bounce_acc", 7, 4'b0010, 4'b0010, 4'b0000);
        btn_raw[1] = 1'b1;
        accept("rel1", 10, 4'b0000, 4'b0000, 4'b0010);
        // simultaneous press and release of buttons 2 and 3
        btn_raw[3:2] = 2'b00;
        accept("multi_press", 10, 4'b1100, 4'b1100, 4'b0000);
        btn_raw[3:2] = 2'b11;
        accept("multi_rel", 10, 4'b0000, 4'b0000, 4'b1100);
        // reset in the middle of a debounce with button 3 already accepted
        btn_raw[3] = 1'b0;
        accept("pre_rst3", 10, 4'b1000, 4'b1000, 4'b0000);
        btn_raw[0] = 1'b0;
        step(4);
        ext_reset = 1'b0;
        #1;
        chk("async_rst_level", btn_level, 4'b0000);
        chk("async_rst_press", btn_press, 4'b0000);
        chk("async_rst_release", btn_release, 4'b0000);
        step(2);
        chk("held_rst_level", btn_level, 4'b0000);
        ext_reset = 1'b1;
        accept("post_rst", 10, 4'b1001, 4'b1001, 4'b0000);
        btn_raw[0] = 1'b1;
        btn_raw[3] = 1'b1;
        accept("post_rst_rel", 10, 4'b0000, 4'b0000, 4'b1001);
        // hold button 0; release timed so it is accepted when a repeat is due
        btn_raw[0] = 1'b0;
        accept("rep_acc", 10, 4'b0001, 4'b0001, 4'b0000);
        for (int i = 2; i <= 90; i++) begin
            step(1);
            chk($sformatf("rep_press_%0d", i), btn_press,
                {3'b000, REP && i >= 20 && i < 70 && (i - 20) % 5 == 0});
            chk($sformatf("rep_release_%0d", i), btn_release, {3'b000, i == 70});
            chk($sformatf("rep_level_%0d", i), btn_level, {3'b000, i < 70});
            if (i == 60) btn_raw[0] = 1'b1;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
